spart_driver: RTL and testbench
===============================

# spart_driver

Processor-side bus master for the SPART register interface; the initiator for the iocs/iorw/ioaddr/databus port the SPART answers. After reset it programs the 16-bit baud divisor from a 2-bit switch setting, then runs an echo loop: poll status, read each received byte, wait for transmit-buffer-ready, and write the byte back for transmission. It sits at the top level beside the SPART, in place of a CPU.

## Interface
- TBR_TO_W, 20: width of the tbr-wait watchdog counter; timeout after 2^TBR_TO_W−1 cycles in WAIT_TBR.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
- iocs  out  1  SPART chip select.
- iorw  out  1  1=read, 0=write.
- ioaddr  out  2  00 tx/rx buffer, 01 status (read), 10 divisor low (write), 11 divisor high (write).
- databus  inout  8  driven only when iocs=1 and iorw=0; otherwise 8'bz.
- rx_byte  out  8  last byte read from the receive buffer.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- overrun  out  1  sticky: rda seen while a byte was still pending.
- tx_timeout  out  1  sticky: watchdog expired in WAIT_TBR; pending byte dropped.

## Operation
- Status byte: bit0 rda (one-cycle pulse), bit1 tbr; other bits ignored.
- Divisor per br_cfg (= round(50e6/(16·baud))−1): 4800→0x028A, 9600→0x0145, 19200→0x00A2, 38400→0x0050.
- States and bus outputs (iocs, iorw, ioaddr):
  - IDLE: 0, 1, 01. Unconditionally → INIT_LO.
  - INIT_LO: 1, 0, 10, databus=div[7:0]. → INIT_HI.
  - INIT_HI: 1, 0, 11, databus=div[15:8]. → POLL.
  - POLL: 1, 1, 01. databus[0]=1 → READ; else stay.
  - READ: 1, 1, 00. Capture databus into rx_byte at clock edge. → WAIT_TBR.
  - WAIT_TBR: 1, 1, 01. databus[1]=1 → WRITE; watchdog expiry → set tx_timeout, → POLL; else stay.
  - WRITE: 1, 0, 00, databus=rx_byte. → POLL.
- Watchdog clears on entry to WAIT_TBR and increments each WAIT_TBR cycle.
- databus[0]=1 sampled in WAIT_TBR sets overrun; new byte is dropped, pending byte kept.
- br_cfg registered as br_cfg_q; br_cfg≠br_cfg_q in any state → next state INIT_LO (pending byte dropped, no write issued); divisor taken from the new value. Takes priority over every other transition.
- Divisor table is combinational from br_cfg_q.
- Reset: state IDLE, iocs=0, iorw=1, ioaddr=01, databus Z, rx_byte=0, rx_valid=0, overrun=0, tx_timeout=0, watchdog=0, br_cfg_q=br_cfg.
- Sticky flags clear only on rst.

## Timing
- Bus outputs are registered; each state lasts one cycle except POLL/WAIT_TBR.
- Reads are combinational on the SPART side: data sampled at the end of the same cycle the address is presented.
- Reset release at edge 0: INIT_LO during cycle 1, INIT_HI cycle 2, first POLL cycle 3.
- rda seen in POLL cycle N: READ cycle N+1; rx_byte and rx_valid=1 in cycle N+2 (state WAIT_TBR); if tbr=1 in N+2, WRITE in N+3, POLL in N+4. Minimum echo latency 4 cycles.
- Every write strobe (iocs=1, iorw=0) lasts exactly one cycle; databus is driven only in that cycle.
- rst mid-operation: next cycle IDLE regardless of state; no partial write.

## Structure
- Package spart_pkg: state_t enum, ioaddr constants (ADDR_BUF, ADDR_STATUS, ADDR_DB_LO, ADDR_DB_HI), status bit indices, divisor constants.
- Sub-module spart_div_sel: br_cfg → 16-bit divisor lookup.
- Tristate assign in spart_driver itself.

## Test plan
- Reset, br_cfg=01 -> writes 0x45 to addr 10 in cycle 1, 0x01 to addr 11 in cycle 2, POLL with iorw=1 thereafter.
- SPART model pulses rda with rx buffer 0x5A, tbr=1 -> rx_valid pulse with rx_byte=0x5A two cycles later, write of 0x5A to addr 00 one cycle after.
- tbr held 0 for 100 cycles after a receive, then 1 -> write of held byte occurs one cycle after tbr rises; tx_timeout stays 0.
- Second rda pulse during WAIT_TBR (byte 0x33 after 0x11) -> overrun=1, 0x11 echoed, 0x33 never written.
- br_cfg 01→11 while in POLL -> INIT_LO writes 0x50, INIT_HI writes 0x00, return to POLL; same change during WAIT_TBR -> no echo write.
- TBR_TO_W=4, tbr stuck 0 -> tx_timeout=1 after 15 WAIT_TBR cycles, back to POLL, no write issued.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART bus master: FSM states, register
// addresses, status bit positions, baud divisors and the per-state bus decode.
package spart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_LO,
        ST_INIT_HI,
        ST_POLL,
        ST_READ,
        ST_WAIT_TBR,
        ST_WRITE
    } state_t;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    localparam int STAT_RDA = 0;
    localparam int STAT_TBR = 1;

    // round(50 MHz / (16 * baud)) - 1
    localparam logic [15:0] DIV_4800  = 16'h028A;
    localparam logic [15:0] DIV_9600  = 16'h0145;
    localparam logic [15:0] DIV_19200 = 16'h00A2;
    localparam logic [15:0] DIV_38400 = 16'h0050;

    typedef struct packed {
        logic       iocs;
        logic       iorw;
        logic [1:0] ioaddr;
    } bus_t;

    // Bus control presented while the FSM sits in a given state.
    function automatic bus_t bus_for(input state_t st);
        bus_t b;
        b.iocs   = 1'b1;
        b.iorw   = 1'b1;
        b.ioaddr = ADDR_STATUS;
        case (st)
            ST_IDLE:    b.iocs = 1'b0;
            ST_INIT_LO: begin b.iorw = 1'b0; b.ioaddr = ADDR_DB_LO; end
            ST_INIT_HI: begin b.iorw = 1'b0; b.ioaddr = ADDR_DB_HI; end
            ST_READ:    b.ioaddr = ADDR_BUF;
            ST_WRITE:   begin b.iorw = 1'b0; b.ioaddr = ADDR_BUF; end
            default:    ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spart_div_sel.sv
// Baud select to 16-bit SPART divisor lookup.
module spart_div_sel
    import spart_pkg::*;
(
    input  logic [1:0]  br_cfg,
    output logic [15:0] divisor
);

    always_comb begin
        divisor = DIV_9600;
        case (br_cfg)
            2'b00: divisor = DIV_4800;
            2'b01: divisor = DIV_9600;
            2'b10: divisor = DIV_19200;
            2'b11: divisor = DIV_38400;
            default: divisor = DIV_9600;
        endcase
    end

endmodule

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor after reset or a br_cfg change,
// then echoes every received byte back to the transmitter.
module spart_driver
    import spart_pkg::*;
#(
    parameter int TBR_TO_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       overrun,
    output logic       tx_timeout
);

    // Last watchdog value before expiry: 2^W-2, i.e. the (2^W-1)th WAIT_TBR cycle.
    localparam logic [TBR_TO_W-1:0] WD_LAST = {{(TBR_TO_W-1){1'b1}}, 1'b0};

    state_t              state_reg, state_next;
    bus_t                bus_reg;
    logic [1:0]          br_cfg_reg;
    logic [15:0]         divisor;
    logic [7:0]          rx_byte_reg;
    logic                rx_valid_reg;
    logic                overrun_reg;
    logic                tx_timeout_reg;
    logic [TBR_TO_W-1:0] wd_reg;
    logic [7:0]          wr_data;
    logic                drive;
    logic                rda;
    logic                tbr;
    logic                cfg_change;
    logic                wd_expired;

    spart_div_sel u_div_sel (
        .br_cfg  (br_cfg_reg),
        .divisor (divisor)
    );

    assign rda        = databus[STAT_RDA];
    assign tbr        = databus[STAT_TBR];
    assign cfg_change = (br_cfg != br_cfg_reg);
    assign wd_expired = (wd_reg == WD_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     state_next = ST_INIT_LO;
            ST_INIT_LO:  state_next = ST_INIT_HI;
            ST_INIT_HI:  state_next = ST_POLL;
            ST_POLL:     if (rda) state_next = ST_READ;
            ST_READ:     state_next = ST_WAIT_TBR;
            ST_WAIT_TBR: begin
                if (tbr)
                    state_next = ST_WRITE;
                else if (wd_expired)
                    state_next = ST_POLL;
            end
            ST_WRITE:    state_next = ST_POLL;
            default:     state_next = ST_IDLE;
        endcase
        // A new baud setting abandons whatever is in flight and reprograms.
        if (cfg_change)
            state_next = ST_INIT_LO;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            bus_reg        <= bus_for(ST_IDLE);
            br_cfg_reg     <= br_cfg;
            rx_byte_reg    <= 8'h00;
            rx_valid_reg   <= 1'b0;
            overrun_reg    <= 1'b0;
            tx_timeout_reg <= 1'b0;
            wd_reg         <= '0;
        end else begin
            state_reg    <= state_next;
            bus_reg      <= bus_for(state_next);
            br_cfg_reg   <= br_cfg;
            rx_valid_reg <= 1'b0;
            if (state_reg == ST_READ && !cfg_change) begin
                rx_byte_reg  <= databus;
                rx_valid_reg <= 1'b1;
            end
            if (state_reg == ST_WAIT_TBR && rda)
                overrun_reg <= 1'b1;
            // Leaving WAIT_TBR straight to POLL can only mean the watchdog fired.
            if (state_reg == ST_WAIT_TBR && state_next == ST_POLL)
                tx_timeout_reg <= 1'b1;
            if (state_next == ST_WAIT_TBR && state_reg != ST_WAIT_TBR)
                wd_reg <= '0;
            else if (state_reg == ST_WAIT_TBR)
                wd_reg <= wd_reg + 1'b1;
        end
    end

    always_comb begin
        wr_data = rx_byte_reg;
        case (state_reg)
            ST_INIT_LO: wr_data = divisor[7:0];
            ST_INIT_HI: wr_data = divisor[15:8];
            default:    wr_data = rx_byte_reg;
        endcase
    end

    assign drive   = bus_reg.iocs && !bus_reg.iorw;
    assign databus = drive ? wr_data : 8'bz;

    assign iocs       = bus_reg.iocs;
    assign iorw       = bus_reg.iorw;
    assign ioaddr     = bus_reg.ioaddr;
    assign rx_byte    = rx_byte_reg;
    assign rx_valid   = rx_valid_reg;
    assign overrun    = overrun_reg;
    assign tx_timeout = tx_timeout_reg;

endmodule

// File: tb/tb_spart_driver.sv
// Scoreboard bench for spart_driver: a behavioural SPART answers the bus, the
// stimulus queues expected writes/receives with their cycle, a monitor checks them.
module tb_spart_driver;

    localparam int TO_W      = 7;
    localparam int WD_CYCLES = (1 << TO_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    wire        iocs, iorw;
    wire  [1:0] ioaddr;
    wire  [7:0] databus;
    wire  [7:0] rx_byte;
    wire        rx_valid, overrun, tx_timeout;

    logic       rda = 1'b0;
    logic       tbr = 1'b1;
    logic [7:0] rx_buf = 8'h00;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        int         cyc;
    } txn_t;

    txn_t exp_wr[$];
    txn_t exp_rx[$];
    txn_t mon_e;

    spart_driver #(.TBR_TO_W(TO_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .overrun    (overrun),
        .tx_timeout (tx_timeout)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPART register file seen from the bus: combinational reads.
    assign databus = (iocs && iorw)
                   ? ((ioaddr == 2'b01) ? {6'b0, tbr, rda}
                     : (ioaddr == 2'b00) ? rx_buf : 8'h00)
                   : 8'bz;

    function automatic logic [15:0] ref_div(input logic [1:0] cfg);
        int baud;
        baud = 4800 << cfg;
        return 16'((50000000 + 8 * baud) / (16 * baud) - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end else begin
            $display("check %s = %0h ok (cyc %0d)", name, act, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_wr(input logic [1:0] a, input logic [7:0] d, input int c);
        exp_wr.push_back('{a, d, c});
    endtask

    task automatic push_rx(input logic [7:0] d, input int c);
        exp_rx.push_back('{2'b00, d, c});
    endtask

    // Monitor: every write strobe and every rx_valid pulse must match the queue head.
    always @(negedge clk) begin
        if (!rst && iocs && !iorw) begin
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL write: unexpected addr=%0d data=%02h cyc=%0d", ioaddr, databus, cyc);
            end else begin
                mon_e = exp_wr.pop_front();
                if (ioaddr !== mon_e.addr || databus !== mon_e.data || cyc != mon_e.cyc) begin
                    bad++;
                    $display("FAIL write: got addr=%0d data=%02h cyc=%0d expected addr=%0d data=%02h cyc=%0d",
                             ioaddr, databus, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end else begin
                    $display("write addr=%0d data=%02h cyc=%0d ok", ioaddr, databus, cyc);
                end
            end
        end
        if (!rst && rx_valid) begin
            total++;
            if (exp_rx.size() == 0) begin
                bad++;
                $display("FAIL receive: unexpected rx_byte=%02h cyc=%0d", rx_byte, cyc);
            end else begin
                mon_e = exp_rx.pop_front();
                if (rx_byte !== mon_e.data || cyc != mon_e.cyc) begin
                    bad++;
                    $display("FAIL receive: got rx_byte=%02h cyc=%0d expected rx_byte=%02h cyc=%0d",
                             rx_byte, cyc, mon_e.data, mon_e.cyc);
                end else begin
                    $display("receive rx_byte=%02h cyc=%0d ok", rx_byte, cyc);
                end
            end
        end
    end

    // Reset, check the idle outputs, expect the two divisor writes, land in POLL.
    task automatic do_reset();
        int t0;
        logic [15:0] dv;
        rst = 1'b1;
        tick();
        tick();
        check("rst_iocs", iocs, 1'b0);
        check("rst_iorw", iorw, 1'b1);
        check("rst_ioaddr", ioaddr, 2'b01);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_tx_timeout", tx_timeout, 1'b0);
        t0 = cyc;
        dv = ref_div(br_cfg);
        push_wr(2'b10, dv[7:0], t0 + 1);
        push_wr(2'b11, dv[15:8], t0 + 2);
        rst = 1'b0;
        wait_until(t0 + 3);
        check("poll_bus", {iocs, iorw, ioaddr}, {1'b1, 1'b1, 2'b01});
    endtask

    // One received byte while polling, with tbr rising d cycles after WAIT_TBR entry.
    task automatic echo(input logic [7:0] b, input int d);
        int n;
        n = cyc;
        rda = 1'b1;
        rx_buf = b;
        tbr = (d == 0);
        push_rx(b, n + 2);
        push_wr(2'b00, b, n + 3 + d);
        tick();
        rda = 1'b0;
        wait_until(n + 2 + d);
        tbr = 1'b1;
        wait_until(n + 4 + d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: run did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] dv;
        logic [7:0] b;

        do_reset();

        echo(8'h5A, 0);
        echo(8'hC3, 100);
        check("no_timeout_after_100", tx_timeout, 1'b0);

        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            echo(b, int'($urandom_range(0, 6)));
            repeat (int'($urandom_range(0, 3))) tick();
        end
        check("overrun_clear", overrun, 1'b0);

        // Second rda while the first byte waits for tbr.
        n = cyc;
        rda = 1'b1; rx_buf = 8'h11; tbr = 1'b0;
        push_rx(8'h11, n + 2);
        push_wr(2'b00, 8'h11, n + 9);
        tick(); rda = 1'b0;
        wait_until(n + 4);
        rda = 1'b1; rx_buf = 8'h33;
        tick(); rda = 1'b0;
        wait_until(n + 8);
        tbr = 1'b1;
        wait_until(n + 11);
        check("overrun_set", overrun, 1'b1);

        // Baud change while polling.
        n = cyc;
        br_cfg = 2'b11;
        dv = ref_div(2'b11);
        push_wr(2'b10, dv[7:0], n + 1);
        push_wr(2'b11, dv[15:8], n + 2);
        wait_until(n + 3);
        check("cfg_poll_bus", {iocs, iorw, ioaddr}, {1'b1, 1'b1, 2'b01});
        echo(8'hA7, 1);

        // Baud change while a byte waits for tbr: byte dropped, no echo.
        n = cyc;
        rda = 1'b1; rx_buf = 8'h77; tbr = 1'b0;
        push_rx(8'h77, n + 2);
        tick(); rda = 1'b0;
        wait_until(n + 3);
        br_cfg = 2'b10;
        dv = ref_div(2'b10);
        push_wr(2'b10, dv[7:0], n + 4);
        push_wr(2'b11, dv[15:8], n + 5);
        tick();
        tbr = 1'b1;
        wait_until(n + 8);
        echo(8'h1E, 0);

        // tbr stuck low: watchdog fires after WD_CYCLES cycles in WAIT_TBR.
        n = cyc;
        rda = 1'b1; rx_buf = 8'hE7; tbr = 1'b0;
        push_rx(8'hE7, n + 2);
        tick(); rda = 1'b0;
        wait_until(n + 1 + WD_CYCLES);
        check("timeout_not_yet", tx_timeout, 1'b0);
        tick();
        check("timeout_set", tx_timeout, 1'b1);
        tbr = 1'b1;
        tick();
        echo(8'h3C, 0);
        check("timeout_sticky", tx_timeout, 1'b1);

        // Reset in the middle of WAIT_TBR: no write, sticky flags cleared.
        n = cyc;
        rda = 1'b1; rx_buf = 8'h99; tbr = 1'b0;
        push_rx(8'h99, n + 2);
        tick(); rda = 1'b0;
        wait_until(n + 3);
        do_reset();
        tbr = 1'b1;
        echo(8'h42, 2);

        repeat (6) tick();
        check("wr_queue_empty", exp_wr.size(), 0);
        check("rx_queue_empty", exp_rx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
